// File: rtl/rsa_uart_tx_bridge.sv
// rtl/rsa_uart_tx_bridge.sv - byte-strobe to 8N1 UART transmit bridge with FIFO
//
// Buffers bytes from the interpreter communication unit and sends them to the
// host as 8N1 UART frames, in arrival order.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//   FIFO_DEPTH    byte buffer depth (power of 2, >= 2)
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   byte_clk    byte strobe; a rising edge marks a valid byte
//   byte_in     byte value, captured two cycles after the strobe is first seen
//   tx          UART serial output, idle high
//   busy        transmitter active or bytes still buffered
//   fifo_count  number of bytes currently buffered
//   overflow    sticky flag, set when a byte is dropped on a full FIFO

module rsa_uart_tx_bridge #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          byte_clk,
   input  logic [7:0]                    byte_in,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nx;
   logic          sync1, sync2, sync_dly;
   logic          push, push_ok, pop;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count_nx;
   logic [BW-1:0] baud, baud_nx;
   logic [2:0]    bit_cnt, bit_cnt_nx;
   logic [7:0]    shift, shift_nx;
   logic          baud_done;
   logic          tx_nx, busy_nx;

   // Strobe synchroniser; the delay flop turns a level of any length into one push.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         sync_dly <= 1'b0;
      end else begin
         sync1    <= byte_clk;
         sync2    <= sync1;
         sync_dly <= sync2;
      end
   end

   assign push = sync2 & ~sync_dly;
   assign pop  = (state == IDLE) && (fifo_count != '0);
   // A full FIFO still accepts a byte when the head leaves on the same edge.
   assign push_ok = push && ((fifo_count < DEPTH_C) || pop);

   always_comb begin
      count_nx = fifo_count;
      if (push_ok && !pop)
         count_nx = fifo_count + 1'b1;
      else if (!push_ok && pop)
         count_nx = fifo_count - 1'b1;
   end

   // Storage is not reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= byte_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         fifo_count <= count_nx;
         if (push && !push_ok)
            overflow <= 1'b1;
      end
   end

   assign baud_done = (baud == BAUD_LAST);

   // State register; tx and busy are registered from next-state values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state   <= state_nx;
         baud    <= baud_nx;
         bit_cnt <= bit_cnt_nx;
         shift   <= shift_nx;
         tx      <= tx_nx;
         busy    <= busy_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx   = state;
      baud_nx    = baud;
      bit_cnt_nx = bit_cnt;
      shift_nx   = shift;
      case (state)
         IDLE: begin
            if (pop) begin
               shift_nx   = mem[rd_ptr];
               bit_cnt_nx = '0;
               baud_nx    = '0;
               state_nx   = START;
            end
         end
         START: begin
            if (baud_done) begin
               baud_nx  = '0;
               state_nx = DATA;
            end else begin
               baud_nx = baud + 1'b1;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_nx  = '0;
               shift_nx = {1'b0, shift[7:1]};
               if (bit_cnt == 3'd7)
                  state_nx = STOP;
               else
                  bit_cnt_nx = bit_cnt + 3'd1;
            end else begin
               baud_nx = baud + 1'b1;
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_nx  = '0;
               state_nx = IDLE;
            end else begin
               baud_nx = baud + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Output logic, evaluated on next-state values so tx lands with the state.
   always_comb begin
      tx_nx = 1'b1;
      case (state_nx)
         START:   tx_nx = 1'b0;
         DATA:    tx_nx = shift_nx[0];
         default: tx_nx = 1'b1;
      endcase
      busy_nx = (state_nx != IDLE) || (count_nx != '0);
   end

endmodule

// File: tb/tb_rsa_uart_tx_bridge.sv
// tb/tb_rsa_uart_tx_bridge.sv - directed scoreboard bench for rsa_uart_tx_bridge

module tb_rsa_uart_tx_bridge;

   logic       clk = 1'b0;
   logic       reset;
   logic       bclk_a, bclk_b, bclk_c;
   logic [7:0] bin_a, bin_b, bin_c;
   logic       tx_a, tx_b, tx_c;
   logic       busy_a, busy_b, busy_c;
   logic       ovf_a, ovf_b, ovf_c;
   logic [4:0] cnt_a;
   logic [2:0] cnt_b;
   logic [1:0] cnt_c;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int max_a, max_b, max_c;
   int rd_idx [3];

   logic [7:0] rxq_a [$];
   logic [7:0] rxq_b [$];
   logic [7:0] rxq_c [$];
   int         st_a  [$];
   logic [7:0] exp_a [$];
   logic [7:0] exp_b [$];
   logic [7:0] exp_c [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rsa_uart_tx_bridge #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16)) dut_a (
      .clk(clk), .reset(reset), .byte_clk(bclk_a), .byte_in(bin_a),
      .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a), .overflow(ovf_a));

   rsa_uart_tx_bridge #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .reset(reset), .byte_clk(bclk_b), .byte_in(bin_b),
      .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b), .overflow(ovf_b));

   rsa_uart_tx_bridge #(.CLKS_PER_BIT(4), .FIFO_DEPTH(2)) dut_c (
      .clk(clk), .reset(reset), .byte_clk(bclk_c), .byte_in(bin_c),
      .tx(tx_c), .busy(busy_c), .fifo_count(cnt_c), .overflow(ovf_c));

   function automatic logic tx_of(input int idx);
      case (idx)
         0:       return tx_a;
         1:       return tx_b;
         default: return tx_c;
      endcase
   endfunction

   function automatic int rx_size(input int idx);
      case (idx)
         0:       return rxq_a.size();
         1:       return rxq_b.size();
         default: return rxq_c.size();
      endcase
   endfunction

   function automatic logic [7:0] rx_at(input int idx, input int pos);
      case (idx)
         0:       return rxq_a[pos];
         1:       return rxq_b[pos];
         default: return rxq_c[pos];
      endcase
   endfunction

   // UART receiver: finds the start edge, samples each bit mid-cell.
   task automatic rx_run(input int idx, input int cpb);
      logic       prev;
      logic       cur;
      logic [7:0] d;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         cur = tx_of(idx);
         if (prev === 1'b1 && cur === 1'b0) begin
            if (idx == 0) st_a.push_back(cyc);
            repeat (cpb + cpb / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               d[i] = tx_of(idx);
               repeat (cpb) @(negedge clk);
            end
            case (idx)
               0:       rxq_a.push_back(d);
               1:       rxq_b.push_back(d);
               default: rxq_c.push_back(d);
            endcase
            cur = 1'b1;
         end
         prev = cur;
      end
   endtask

   initial rx_run(0, 4);
   initial rx_run(1, 8);
   initial rx_run(2, 4);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         if (int'(cnt_a) > max_a) max_a = int'(cnt_a);
         if (int'(cnt_b) > max_b) max_b = int'(cnt_b);
         if (int'(cnt_c) > max_c) max_c = int'(cnt_c);
      end
   endtask

   task automatic drive(input int idx, input logic strobe, input logic [7:0] d);
      case (idx)
         0:       begin bin_a = d; bclk_a = strobe; end
         1:       begin bin_b = d; bclk_b = strobe; end
         default: begin bin_c = d; bclk_c = strobe; end
      endcase
   endtask

   task automatic exp_push(input int idx, input logic [7:0] d);
      case (idx)
         0:       exp_a.push_back(d);
         1:       exp_b.push_back(d);
         default: exp_c.push_back(d);
      endcase
   endtask

   // One byte: strobe high for hi cycles, then 3 low; keep=1 means it must arrive.
   task automatic send(input int idx, input logic [7:0] d, input int hi, input bit keep);
      drive(idx, 1'b1, d);
      if (keep) exp_push(idx, d);
      tick(hi);
      drive(idx, 1'b0, d);
      tick(3);
   endtask

   task automatic wait_rx(input int idx, input int n, input int budget, input string tag);
      int b;
      b = 0;
      while ((rx_size(idx) - rd_idx[idx]) < n && b < budget) begin
         tick(1);
         b++;
      end
      chk(tag, rx_size(idx) - rd_idx[idx], n);
   endtask

   task automatic compare_rx(input int idx, input string tag);
      logic [7:0]  e;
      logic [31:0] o;
      int          n;
      n = 0;
      forever begin
         case (idx)
            0: begin if (exp_a.size() == 0) break; e = exp_a.pop_front(); end
            1: begin if (exp_b.size() == 0) break; e = exp_b.pop_front(); end
            default: begin if (exp_c.size() == 0) break; e = exp_c.pop_front(); end
         endcase
         if (rx_size(idx) > rd_idx[idx]) begin
            o = {24'h0, rx_at(idx, rd_idx[idx])};
            rd_idx[idx]++;
         end else begin
            o = 32'hFFFF_FFFF;
         end
         chk($sformatf("%s_byte%0d", tag, n), o, {24'h0, e});
         n++;
      end
   endtask

   initial begin
      int         c0;
      int         base;
      logic [9:0] frame10;

      reset = 1'b0;
      bclk_a = 1'b0; bclk_b = 1'b0; bclk_c = 1'b0;
      bin_a = 8'h00; bin_b = 8'h00; bin_c = 8'h00;
      max_a = 0; max_b = 0; max_c = 0;
      for (int i = 0; i < 3; i++) rd_idx[i] = 0;

      // Reset state
      tick(3);
      chk("rst_tx", tx_a, 1);
      chk("rst_busy", busy_a, 0);
      chk("rst_count", cnt_a, 0);
      chk("rst_overflow", ovf_a, 0);
      reset = 1'b1;
      tick(2);

      // Single byte 0xA5, cycle-exact waveform
      frame10 = {1'b1, 8'hA5, 1'b0};
      drive(0, 1'b1, 8'hA5);
      exp_push(0, 8'hA5);
      tick(3);
      chk("single_tx_before_e3", tx_a, 1);
      chk("single_count_after_e2", cnt_a, 1);
      chk("single_busy_after_e2", busy_a, 1);
      drive(0, 1'b0, 8'hA5);
      tick(1);
      chk("single_count_after_pop", cnt_a, 0);
      for (int k = 0; k < 40; k++) begin
         chk($sformatf("single_wave_k%0d", k), tx_a, frame10[k / 4]);
         if (k == 39) chk("single_busy_last_stop", busy_a, 1);
         tick(1);
      end
      chk("single_tx_end", tx_a, 1);
      chk("single_busy_end", busy_a, 0);
      chk("single_count_end", cnt_a, 0);
      wait_rx(0, 1, 100, "single_rx_avail");
      compare_rx(0, "single");

      // Burst of three bytes
      max_a = 0;
      base = st_a.size();
      send(0, 8'h01, 3, 1'b1);
      send(0, 8'h80, 3, 1'b1);
      send(0, 8'hFF, 3, 1'b1);
      wait_rx(0, 3, 400, "burst_rx_avail");
      compare_rx(0, "burst");
      chk("burst_peak_count", max_a, 2);
      if (st_a.size() >= base + 3) begin
         chk("burst_period_1", st_a[base+1] - st_a[base], 41);
         chk("burst_period_2", st_a[base+2] - st_a[base+1], 41);
      end else begin
         chk("burst_starts", st_a.size() - base, 3);
      end
      tick(10);
      chk("burst_busy_end", busy_a, 0);
      chk("burst_count_end", cnt_a, 0);

      // Overflow on a 4-deep FIFO
      send(1, 8'h10, 3, 1'b1);
      send(1, 8'h11, 3, 1'b1);
      send(1, 8'h12, 3, 1'b1);
      send(1, 8'h13, 3, 1'b1);
      send(1, 8'h14, 3, 1'b1);
      chk("ovf_not_yet", ovf_b, 0);
      chk("ovf_count_full", cnt_b, 4);
      send(1, 8'h15, 3, 1'b0);
      chk("ovf_set", ovf_b, 1);
      chk("ovf_count_held", cnt_b, 4);
      wait_rx(1, 5, 1000, "ovf_rx_avail");
      compare_rx(1, "ovf");
      tick(120);
      chk("ovf_no_extra", rx_size(1) - rd_idx[1], 0);
      chk("ovf_sticky", ovf_b, 1);
      chk("ovf_drained", cnt_b, 0);
      chk("ovf_busy_end", busy_b, 0);

      // Long strobe gives exactly one push
      max_a = 0;
      send(0, 8'h3C, 100, 1'b1);
      wait_rx(0, 1, 200, "long_rx_avail");
      compare_rx(0, "long");
      chk("long_max_count", max_a, 1);
      tick(100);
      chk("long_no_extra", rx_size(0) - rd_idx[0], 0);

      // Asynchronous reset during DATA bit 3 with two bytes queued
      send(0, 8'h11, 3, 1'b0);
      send(0, 8'h22, 3, 1'b0);
      send(0, 8'h33, 3, 1'b0);
      tick(3);
      chk("rstmid_queued", cnt_a, 2);
      chk("rstmid_in_data", busy_a, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("rstmid_tx", tx_a, 1);
      chk("rstmid_busy", busy_a, 0);
      chk("rstmid_count", cnt_a, 0);
      chk("rstmid_overflow", ovf_a, 0);
      chk("rstmid_overflow_b", ovf_b, 0);
      tick(2);
      reset = 1'b1;
      tick(60);
      rd_idx[0] = rx_size(0);
      base = st_a.size();
      tick(200);
      chk("rstmid_no_frames", st_a.size() - base, 0);
      chk("rstmid_tx_idle", tx_a, 1);
      chk("rstmid_busy_idle", busy_a, 0);

      // Push landing on the pop edge of a full 2-deep FIFO
      c0 = cyc;
      send(2, 8'hC1, 3, 1'b1);
      send(2, 8'hC2, 3, 1'b1);
      send(2, 8'hC3, 3, 1'b1);
      chk("full_count", cnt_c, 2);
      tick(c0 + 42 - cyc);
      drive(2, 1'b1, 8'h5A);
      exp_push(2, 8'h5A);
      tick(2);
      chk("full_count_before_pop", cnt_c, 2);
      tick(1);
      chk("full_count_after_pop", cnt_c, 2);
      chk("full_no_overflow", ovf_c, 0);
      drive(2, 1'b0, 8'h5A);
      wait_rx(2, 4, 600, "full_rx_avail");
      compare_rx(2, "full");
      chk("full_overflow_end", ovf_c, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rsa_uart_tx_bridge.md
# rsa_uart_tx_bridge

Downstream output stage for the RSA pipelined CPU. It consumes the byte stream from the interpreter communication unit (`clk_out` strobe plus `ReadDataOut[7:0]`) and buffers the bytes in a small FIFO. It then serialises them as 8N1 UART frames on a single `tx` pin for the host PC, so result bytes are transmitted in arrival order without stalling the CPU.

## Interface
- `CLKS_PER_BIT`, 434, clk cycles per UART bit; minimum 2.
- `FIFO_DEPTH`, 16, byte buffer depth; power of 2, minimum 2.
- `clk`  in  1  system clock (same `clk` as the CPU).
- `reset`  in  1  asynchronous, active-low reset; 0 = reset.
- `byte_clk`  in  1  byte strobe from the interpreter `clk_out`; its rising edge marks a valid byte.
- `byte_in`  in  8  byte from the interpreter `ReadDataOut`.
- `tx`  out  1  UART serial output, idle high.
- `busy`  out  1  high when FSM is not IDLE or FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered.
- `overflow`  out  1  sticky; set when a byte is dropped because the FIFO is full.

## Operation
- Reset (`reset`=0, asynchronous): `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0, FSM=IDLE, FIFO pointers=0, synchroniser flops=0. Any frame in flight is aborted immediately and buffered bytes are discarded.
- Input capture:
  - `byte_clk` passes through a 2-flop synchroniser plus one delay flop.
  - A one-cycle `push` pulse is generated on a rising edge (sync2=1, delayed=0).
  - `byte_in` is sampled on the edge where `push` is high.
  - Holding `byte_clk` high for any length of time produces exactly one push.
- FIFO: circular buffer with wrapping read/write pointers and a `fifo_count` register.
  - A push is accepted when `fifo_count` < `FIFO_DEPTH`, or when a pop occurs in the same cycle.
  - If a push is refused, the byte is dropped and `overflow` is set to 1 and held until reset.
  - Simultaneous push and pop leaves `fifo_count` unchanged.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop one byte into the shift register, clear the bit counter, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=shift[0], LSB first. Each bit is held `CLKS_PER_BIT` cycles, then shift right. After bit 7 completes, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- The baud counter runs 0..`CLKS_PER_BIT`-1, wraps to 0 on each bit boundary, and is cleared on entry to START.
- The bit counter is 3 bits, 0..7; terminal count is 7.
- `tx` is a registered output and is glitch-free.

## Timing
- Let E0 be the first `clk` edge that samples `byte_clk`=1.
  - sync1=1 after E0; sync2=1 after E1; `push` is high in the cycle following E1.
  - The FIFO write and `byte_in` capture happen at E2, so `byte_in` must be stable from E0 through E2.
- With an empty FIFO and the FSM in IDLE:
  - The pop occurs at E3 and FSM=START after E3.
  - `tx` falls after E3, i.e. 3 cycles of latency from E0.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames: one IDLE cycle between the STOP end and the next START, giving a period of 10×`CLKS_PER_BIT`+1 cycles.
- `fifo_count`: increments after E2; decrements at the pop edge.
- `busy` is registered from next-state values and is high from E3 (or earlier while the FIFO is non-empty) until the last STOP cycle ends with the FIFO empty.
- Minimum `byte_clk` spacing between rising edges is 3 clk cycles high plus 3 low. Closer edges may merge into a single push.

## Test plan
- Single byte, `CLKS_PER_BIT`=4: push 0xA5 -> `tx` low 3 cycles after E0, then the 4-cycle bits 0,1,0,1,0,0,1,0,1,1; `busy` falls after 40 cycles; `fifo_count` returns to 0.
- Burst, `CLKS_PER_BIT`=4: push 0x01, 0x80, 0xFF 6 cycles apart -> three frames in order, each 40 cycles with 1 IDLE cycle between; `fifo_count` peaks at 2.
- Overflow, `FIFO_DEPTH`=4, `CLKS_PER_BIT`=8: push 0x10..0x15 (6 bytes) during the first frame -> 0x10..0x14 transmitted (1 in flight + 4 buffered), 0x15 dropped, `overflow`=1 and stays high after the FIFO drains.
- Long strobe: hold `byte_clk` high for 100 cycles with 0x3C -> exactly one frame; `fifo_count` never exceeds 1.
- Reset mid-frame: assert `reset`=0 during DATA bit 3 with 2 bytes queued -> `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0 asynchronously; after release, `tx` stays high with no further frames.
- Simultaneous push and pop at full, `FIFO_DEPTH`=2: push timed to land on the pop edge -> byte accepted, `overflow` stays 0, `fifo_count` stays 2.
